// File: rtl/audio_mixer.sv
// Multi-channel audio mixer: snapshots all channels on a strobe, accumulates
// gain-weighted samples one channel per cycle, then scales, saturates and registers the mix.
module audio_mixer #(
  parameter int NUM_CH      = 4,
  parameter int AUDIO_WIDTH = 16,
  parameter int GAIN_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH*AUDIO_WIDTH-1:0] ch_data_i,
  input  logic [NUM_CH*GAIN_WIDTH-1:0]  ch_gain_i,
  input  logic [NUM_CH-1:0]             ch_mute_i,
  input  logic                          sample_strobe_i,
  input  logic                          clear_i,
  output logic [AUDIO_WIDTH-1:0]        mix_o,
  output logic                          mix_valid_o,
  output logic                          busy_o,
  output logic                          clip_o,
  output logic                          overrun_o,
  output logic [1:0]                    dbg_state
);

  localparam int ACC_W = AUDIO_WIDTH + GAIN_WIDTH + $clog2(NUM_CH) + 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]       idx;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       term;
  logic [ACC_W-1:0]       scaled;
  logic                   sat;
  logic                   clip_set;
  logic                   overrun_set;
  logic [AUDIO_WIDTH-1:0] data_s [NUM_CH];
  logic [GAIN_WIDTH-1:0]  gain_s [NUM_CH];
  logic [NUM_CH-1:0]      mute_s;

  // Handshake: sample_strobe_i is a single-cycle request with no back-pressure;
  // it is accepted only in IDLE, otherwise it is dropped and flagged as overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_strobe_i) state_next = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_next = OUTPUT;
      OUTPUT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign dbg_state = state;
  assign busy_o    = (state != IDLE);

  // Snapshot needs no reset: it is only read after a fresh capture.
  always_ff @(posedge clk) begin
    if (state == IDLE && sample_strobe_i) begin
      for (int n = 0; n < NUM_CH; n++) begin
        data_s[n] <= ch_data_i[n*AUDIO_WIDTH +: AUDIO_WIDTH];
        gain_s[n] <= ch_gain_i[n*GAIN_WIDTH +: GAIN_WIDTH];
      end
      mute_s <= ch_mute_i;
    end
  end

  always_comb begin
    term = '0;
    if (!mute_s[idx]) term = ACC_W'(data_s[idx]) * ACC_W'(gain_s[idx]);
  end

  assign scaled      = acc >> (GAIN_WIDTH - 1);
  assign sat         = |scaled[ACC_W-1:AUDIO_WIDTH];
  assign clip_set    = (state == OUTPUT) && sat;
  assign overrun_set = sample_strobe_i && (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      acc         <= '0;
      mix_o       <= '0;
      mix_valid_o <= 1'b0;
    end else begin
      mix_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_strobe_i) begin
            idx <= '0;
            acc <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + term;
          idx <= idx + 1'b1;
        end
        OUTPUT: begin
          mix_o       <= sat ? {AUDIO_WIDTH{1'b1}} : scaled[AUDIO_WIDTH-1:0];
          mix_valid_o <= 1'b1;
          idx         <= '0;
        end
        default: ;
      endcase
    end
  end

  // Set has priority over clear so a coincident event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      clip_o    <= clip_set    | (clip_o    & ~clear_i);
      overrun_o <= overrun_set | (overrun_o & ~clear_i);
    end
  end

endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of audio input channels (legal range 1..8).
REQ-002 SHALL have parameter AUDIO_WIDTH, default 16, the unsigned sample width for both input and output.
REQ-003 SHALL have parameter GAIN_WIDTH, default 8, the unsigned per-channel gain width; unity gain = 2^(GAIN_WIDTH-1).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-006 SHALL have port ch_data_i, input, NUM_CH*AUDIO_WIDTH bits, channel samples; channel n occupies bits [n*AUDIO_WIDTH +: AUDIO_WIDTH].
REQ-007 SHALL have port ch_gain_i, input, NUM_CH*GAIN_WIDTH bits, per-channel gains, packed in the same way as ch_data_i.
REQ-008 SHALL have port ch_mute_i, input, NUM_CH bits, per-channel mute; 1 = channel contributes 0.
REQ-009 SHALL have port sample_strobe_i, input, 1 bit, a one-cycle request to produce one mixed sample.
REQ-010 SHALL have port clear_i, input, 1 bit, which clears the sticky flags.
REQ-011 SHALL have port mix_o, output, AUDIO_WIDTH bits, the registered mixed sample.
REQ-012 SHALL have port mix_valid_o, output, 1 bit, a one-cycle pulse marking a new mix_o.
REQ-013 SHALL have port busy_o, output, 1 bit, high whenever the state is not IDLE.
REQ-014 SHALL have port clip_o, output, 1 bit, sticky: saturation occurred.
REQ-015 SHALL have port overrun_o, output, 1 bit, sticky: a strobe was dropped.

Function
REQ-016 SHALL implement the states IDLE, ACCUM and OUTPUT.
REQ-017 In IDLE with sample_strobe_i high at edge E0, SHALL snapshot ch_data_i, ch_gain_i and ch_mute_i, clear the accumulator, set the channel index to 0 and enter ACCUM.
REQ-018 Input changes after E0 SHALL NOT affect the sample in progress.
REQ-019 In ACCUM, at each edge E1..E_NUM_CH, SHALL add term[idx] = mute ? 0 : data*gain, then increment idx; at E_NUM_CH SHALL enter OUTPUT.
REQ-020 The accumulator width SHALL be AUDIO_WIDTH+GAIN_WIDTH+clog2(NUM_CH)+1 bits and SHALL never overflow.
REQ-021 At edge E_NUM_CH+1 (OUTPUT to IDLE), SHALL set scaled = acc >> (GAIN_WIDTH-1).
- If scaled > 2^AUDIO_WIDTH-1: mix_o = all ones and clip_o is set.
- Otherwise: mix_o = scaled.
- mix_valid_o is high for exactly that one cycle.
REQ-022 Strobe-to-valid latency SHALL be NUM_CH+1 edges after E0, and the minimum accepted strobe period SHALL be NUM_CH+2 cycles.
REQ-023 A strobe sampled while the state is not IDLE, including the OUTPUT cycle, SHALL be dropped and SHALL set overrun_o; there is no queueing.
REQ-024 A strobe sampled in IDLE during the cycle mix_valid_o is high SHALL be accepted.
REQ-025 mix_o SHALL hold its value between valid pulses.
REQ-026 clear_i SHALL clear clip_o and overrun_o on the next edge; if a set event and clear_i coincide, set SHALL win.
REQ-027 For NUM_CH=1, behaviour SHALL be identical with a single ACCUM cycle.

Reset
REQ-028 While reset is high, SHALL force:
- state = IDLE, idx = 0, accumulator = 0;
- mix_o = 0, mix_valid_o = 0, busy_o = 0, clip_o = 0, overrun_o = 0.
REQ-029 Reset asserted mid-operation SHALL abort the sample; no mix_valid_o SHALL follow.
REQ-030 The first strobe after reset deassertion SHALL be accepted normally.

Verification (NUM_CH=4, AUDIO_WIDTH=16, GAIN_WIDTH=8)
REQ-031 SHALL cover: gains 128, ch0=0x1000, ch1=0x2000, ch2=ch3=0, strobe, then change ch0 to 0xFFFF at E1 -> mix_o=0x3000, mix_valid_o one cycle after E5, busy_o high E0..E5, clip_o=0.
REQ-032 SHALL cover: ch0=ch1=0xC000, gains 128 -> mix_o=0xFFFF and clip_o=1; clip_o stays 1 through a later unclipped sample until clear_i is pulsed, then 0.
REQ-033 SHALL cover: ch0=0x8000 gain 64 -> 0x4000; then ch0=0x0100 gain 255 -> 0x01FE (other channels 0).
REQ-034 SHALL cover: ch2=0xFFFF gain 128 with ch_mute_i[2]=1, others 0 -> mix_o=0x0000, clip_o=0.
REQ-035 SHALL cover: strobe at E0 and again at E2 -> exactly one mix_valid_o, overrun_o=1; a strobe in the valid cycle is accepted with overrun_o unchanged.
REQ-036 SHALL cover: reset pulsed at E2 of a sample -> all outputs 0, no valid pulse; the next strobe yields the correct mix NUM_CH+1 edges later.
